// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port bundle between mem_stage_ctrl (master) and the memory (slave).
interface mem_stage_ctrl_if;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_ack;
  logic [15:0] dm_rdata;

  modport master (
    output dm_req, dm_wr, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_wr, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Multi-cycle MEM-stage controller: one outstanding load/store, pipeline stall until ack.
// Optional WAIT timeout is compiled in with `define MEM_STAGE_TIMEOUT_EN.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        stall,
  output logic [15:0] rdata,
  output logic        align_err,
  output logic        timeout_err,
  mem_stage_ctrl_if.master dm
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_stage_ctrl: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        accept;

`ifdef MEM_STAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  // Gating with rst keeps stall low while reset is held, even with a live op in EX/MEM.
  always_comb begin
    accept    = rst && (state_q == S_IDLE) && in_valid && mem_en && !addr[0];
    align_err = rst && in_valid && mem_en && addr[0];
  end

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef MEM_STAGE_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d  = addr;
          wdata_d = wdata;
          wr_d    = mem_wr;
          state_d = S_WAIT;
`ifdef MEM_STAGE_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (dm.dm_ack) begin
          if (!wr_q) rdata_d = dm.dm_rdata;
          state_d = S_DONE;
        end
`ifdef MEM_STAGE_TIMEOUT_EN
        // The counter reaches TIMEOUT on this edge: give up, keep rdata as is.
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          cnt_d   = CNT_W'(TIMEOUT);
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_STAGE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign stall       = accept || (state_q == S_WAIT);
  assign rdata       = rdata_q;
  assign dm.dm_req   = (state_q == S_WAIT);
  assign dm.dm_wr    = wr_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Multi-cycle data-memory stage controller for the 16-bit five-stage pipeline. Sits between the EX/MEM latch and the MEM/WB latch, replacing the single-cycle data memory path. Issues one load or store at a time to a variable-latency memory port and freezes the pipeline with `stall` until the access completes. Presents a stable 16-bit read result to the MEM/WB latch.

## Interface
Parameters:
- `TIMEOUT`, 64: cycles allowed in WAIT before a timeout error; only used when the timeout feature is compiled in.

Ports:
- `clk`  input  1  pipeline clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  EX/MEM latch holds a live instruction.
- `mem_en`  input  1  instruction accesses data memory (EX/MEM DMemEn).
- `mem_wr`  input  1  access is a store (EX/MEM DMemWrite); 0 means a load.
- `addr`  input  16  byte address (EX/MEM aluOutput).
- `wdata`  input  16  store data (EX/MEM B).
- `stall`  output  1  freezes PC, IF/ID, ID/EX and EX/MEM; MEM/WB captures a bubble while it is 1.
- `rdata`  output  16  load result for the MEM/WB latch.
- `align_err`  output  1  misaligned access in the current cycle.
- `timeout_err`  output  1  sticky memory-timeout flag.
- `dm_req`  output  1  request to the memory port.
- `dm_wr`  output  1  request is a write.
- `dm_addr`  output  16  registered address.
- `dm_wdata`  output  16  registered write data.
- `dm_ack`  input  1  memory completion; a one-cycle pulse.
- `dm_rdata`  input  16  read data; valid only in the `dm_ack` cycle.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- A request is accepted when the FSM is in IDLE and `in_valid & mem_en & ~addr[0]` is true.
- IDLE:
  - On accept, latch `addr`, `wdata` and `mem_wr` into `dm_addr`, `dm_wdata` and `dm_wr`, then go to WAIT.
  - Any other input leaves the FSM in IDLE.
- WAIT:
  - `dm_req` is 1.
  - On `dm_ack`: if the held op is a load, capture `dm_rdata` into the read hold register. Then go to DONE.
- DONE:
  - Lasts one cycle. `stall` is 0, so the pipeline advances and MEM/WB captures `rdata`.
  - The next state is always IDLE. The still-present EX/MEM op is never re-accepted in DONE.
- `stall` = (IDLE & accept) | WAIT. It is combinational. It is 0 in DONE, and 0 for non-memory or invalid ops.
- `rdata` is always the read hold register. Stores and non-memory ops leave it unchanged.
- Misaligned access (`in_valid & mem_en & addr[0]`):
  - `align_err` is 1 combinationally and no request is issued.
  - `stall` stays 0 and the op passes through.
- Only one outstanding access. `dm_ack` outside WAIT is ignored.

## Timing
- Reset values: state IDLE. `stall`, `dm_req`, `dm_wr`, `align_err` and `timeout_err` are 0. `dm_addr`, `dm_wdata` and `rdata` are 0x0000.
- Access sequence:
  - C0: accept, `stall` is 1.
  - C1: `dm_req` is 1.
  - Ck: `dm_ack`.
  - Ck+1: DONE, `stall` is 0.
- Minimum penalty with an ack in C1: `stall` is high in C0 and C1; DONE is C2. That is 2 stall cycles.
- `dm_addr`, `dm_wdata` and `dm_wr` are stable from C1 until the FSM leaves WAIT.
- `dm_ack` together with `rst` asserted: reset wins. Nothing is captured and the state becomes IDLE.
- Reset asserted mid-WAIT: outputs go to their reset values asynchronously and the in-flight access is abandoned.
- The cycle after DONE is IDLE. A back-to-back memory op in EX/MEM is accepted there.

## Configuration
- `MEM_STAGE_TIMEOUT_EN` defined:
  - A counter, clog2(TIMEOUT+1) bits wide, clears on entry to WAIT and increments each WAIT cycle without `dm_ack`.
  - When it reaches `TIMEOUT`: set `timeout_err` (sticky until reset), go to DONE, and leave `rdata` unchanged.
- Not defined:
  - No counter. WAIT holds indefinitely until `dm_ack`.
  - `timeout_err` is tied to 0.

## Test plan
- Load, ack in C1:
  - Stimulus: `addr`=0x0010, `mem_wr`=0, `dm_rdata`=0xBEEF.
  - Response: `stall` is 1 for exactly 2 cycles; `dm_req` is 1 in C1; `rdata`=0xBEEF in DONE; IDLE after.
- Store, ack in C4:
  - Stimulus: `addr`=0x0020, `wdata`=0x1234.
  - Response: `dm_wr`=1 and `dm_wdata`=0x1234 held C1–C4; `stall` is 1 in C0–C4; `rdata` unchanged.
- Back-to-back:
  - Stimulus: a load from 0x0002, then a load from 0x0004, each acked 3 cycles after `dm_req` rises.
  - Response: two distinct requests; the second is accepted in the cycle after the first DONE; both values appear on `rdata` in order.
- Misaligned:
  - Stimulus: `addr`=0x0011 with `mem_en`=1.
  - Response: `align_err` is 1 in the same cycle; `dm_req` stays 0; `stall` stays 0.
- Reset mid-WAIT:
  - Stimulus: drive `rst` low in C2 of a pending load.
  - Response: `stall` and `dm_req` go to 0 immediately; a later `dm_ack` is ignored; `rdata`=0x0000.
- Timeout, with `MEM_STAGE_TIMEOUT_EN` defined and `TIMEOUT`=8:
  - Stimulus: a load with no ack.
  - Response: `timeout_err` rises after 8 WAIT cycles; DONE follows; the flag stays high until reset.
